// File: rtl/csr_access_sequencer.sv
// Sequences core/debug CSR accesses as read-check-modify-write over a single-ported CSR file.
// Define CSR_ARB_RR_EN for round-robin arbitration; default is fixed debug-over-core priority.
module csr_access_sequencer #(
    parameter int unsigned DW         = 32,
    parameter logic [11:0] DBG_CSR_LO = 12'h7B0,
    parameter logic [11:0] DBG_CSR_HI = 12'h7B3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          core_req_i,
    output logic          core_gnt_o,
    input  logic [11:0]   core_addr_i,
    input  logic [1:0]    core_op_i,
    input  logic [DW-1:0] core_wdata_i,
    input  logic [1:0]    core_priv_i,
    output logic          core_rvalid_o,
    output logic [DW-1:0] core_rdata_o,
    output logic          core_err_o,
    input  logic          dbg_req_i,
    output logic          dbg_gnt_o,
    input  logic [11:0]   dbg_addr_i,
    input  logic [1:0]    dbg_op_i,
    input  logic [DW-1:0] dbg_wdata_i,
    output logic          dbg_rvalid_o,
    output logic [DW-1:0] dbg_rdata_o,
    output logic          dbg_err_o,
    input  logic          debug_mode_i,
    output logic          csr_re_o,
    output logic          csr_we_o,
    output logic [11:0]   csr_addr_o,
    output logic [DW-1:0] csr_wdata_o,
    input  logic [DW-1:0] csr_rdata_i,
    input  logic          csr_illegal_i
);

    typedef enum logic [2:0] {IDLE, READ, EVAL, WRITE, RESP} state_e;
    typedef enum logic [1:0] {OP_READ = 2'b00, OP_WRITE = 2'b01, OP_SET = 2'b10, OP_CLEAR = 2'b11} op_e;

    state_e        state_q, state_d;
    logic          owner_q, owner_d;   // 1 = debug; doubles as last-granted owner
    logic [11:0]   addr_q, addr_d;
    op_e           op_q, op_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] old_q, old_d;
    logic          err_q, err_d;
    logic          re_q, re_d, we_q, we_d;
    logic [11:0]   caddr_q, caddr_d;
    logic [DW-1:0] cwdata_q, cwdata_d;
    logic          core_rvalid_q, dbg_rvalid_q, core_err_q, dbg_err_q;
    logic [DW-1:0] core_rdata_q, dbg_rdata_q;

    logic          grant, sel_dbg, pre_illegal, suppress, resp_core, resp_dbg;
    logic [11:0]   req_addr;
    op_e           req_op;
    logic [DW-1:0] req_wdata, new_val;
    logic [1:0]    req_priv;

    always_comb begin
`ifdef CSR_ARB_RR_EN
        sel_dbg = dbg_req_i && (!core_req_i || !owner_q);
`else
        sel_dbg = dbg_req_i;
`endif
        grant     = (state_q == IDLE) && (core_req_i || dbg_req_i);
        req_addr  = sel_dbg ? dbg_addr_i : core_addr_i;
        req_op    = sel_dbg ? op_e'(dbg_op_i) : op_e'(core_op_i);
        req_wdata = sel_dbg ? dbg_wdata_i : core_wdata_i;
        req_priv  = sel_dbg ? 2'b11 : core_priv_i;
        pre_illegal = (req_addr[9:8] > req_priv) ||
                      (!sel_dbg && !debug_mode_i &&
                       (req_addr >= DBG_CSR_LO) && (req_addr <= DBG_CSR_HI));

        unique case (op_q)
            OP_WRITE: new_val = wdata_q;
            OP_SET:   new_val = csr_rdata_i | wdata_q;
            OP_CLEAR: new_val = csr_rdata_i & ~wdata_q;
            default:  new_val = csr_rdata_i;
        endcase
        suppress = (op_q == OP_READ) ||
                   (((op_q == OP_SET) || (op_q == OP_CLEAR)) && (wdata_q == '0));
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        op_d     = op_q;
        wdata_d  = wdata_q;
        old_d    = old_q;
        err_d    = err_q;
        re_d     = 1'b0;
        we_d     = 1'b0;
        caddr_d  = '0;
        cwdata_d = '0;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    owner_d = sel_dbg;
                    addr_d  = req_addr;
                    op_d    = req_op;
                    wdata_d = req_wdata;
                    old_d   = '0;
                    err_d   = pre_illegal;
                    if (pre_illegal) begin
                        state_d = RESP;
                    end else begin
                        state_d = READ;
                        re_d    = 1'b1;
                        caddr_d = req_addr;
                    end
                end
            end
            READ: state_d = EVAL;
            EVAL: begin
                // Unimplemented address, or a real write to a read-only CSR, errors with zero data
                if (csr_illegal_i || (!suppress && (addr_q[11:10] == 2'b11))) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    old_d   = '0;
                end else begin
                    old_d = csr_rdata_i;
                    err_d = 1'b0;
                    if (suppress) begin
                        state_d = RESP;
                    end else begin
                        state_d  = WRITE;
                        we_d     = 1'b1;
                        caddr_d  = addr_q;
                        cwdata_d = new_val;
                    end
                end
            end
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        resp_core = (state_d == RESP) && !owner_d;
        resp_dbg  = (state_d == RESP) && owner_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            owner_q       <= 1'b1;
            addr_q        <= '0;
            op_q          <= OP_READ;
            wdata_q       <= '0;
            old_q         <= '0;
            err_q         <= 1'b0;
            re_q          <= 1'b0;
            we_q          <= 1'b0;
            caddr_q       <= '0;
            cwdata_q      <= '0;
            core_rvalid_q <= 1'b0;
            dbg_rvalid_q  <= 1'b0;
            core_err_q    <= 1'b0;
            dbg_err_q     <= 1'b0;
            core_rdata_q  <= '0;
            dbg_rdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            addr_q        <= addr_d;
            op_q          <= op_d;
            wdata_q       <= wdata_d;
            old_q         <= old_d;
            err_q         <= err_d;
            re_q          <= re_d;
            we_q          <= we_d;
            caddr_q       <= caddr_d;
            cwdata_q      <= cwdata_d;
            core_rvalid_q <= resp_core;
            dbg_rvalid_q  <= resp_dbg;
            core_err_q    <= resp_core && err_d;
            dbg_err_q     <= resp_dbg && err_d;
            if (resp_core) core_rdata_q <= old_d;
            if (resp_dbg)  dbg_rdata_q  <= old_d;
        end
    end

    assign core_gnt_o    = grant && !sel_dbg;
    assign dbg_gnt_o     = grant && sel_dbg;
    assign core_rvalid_o = core_rvalid_q;
    assign core_rdata_o  = core_rdata_q;
    assign core_err_o    = core_err_q;
    assign dbg_rvalid_o  = dbg_rvalid_q;
    assign dbg_rdata_o   = dbg_rdata_q;
    assign dbg_err_o     = dbg_err_q;
    assign csr_re_o      = re_q;
    assign csr_we_o      = we_q;
    assign csr_addr_o    = caddr_q;
    assign csr_wdata_o   = cwdata_q;

endmodule

// File: tb/tb_csr_access_sequencer.sv
// Self-checking bench for csr_access_sequencer: vector table, response scoreboard, reset and arbitration sequences.
module tb_csr_access_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req_i, core_gnt_o, core_rvalid_o, core_err_o;
    logic [11:0] core_addr_i;
    logic [1:0]  core_op_i, core_priv_i;
    logic [31:0] core_wdata_i, core_rdata_o;
    logic        dbg_req_i, dbg_gnt_o, dbg_rvalid_o, dbg_err_o;
    logic [11:0] dbg_addr_i;
    logic [1:0]  dbg_op_i;
    logic [31:0] dbg_wdata_i, dbg_rdata_o;
    logic        debug_mode_i, csr_re_o, csr_we_o, csr_illegal_i;
    logic [11:0] csr_addr_o;
    logic [31:0] csr_wdata_o, csr_rdata_i;

    always #5 clk = ~clk;

    csr_access_sequencer #(.DW(32), .DBG_CSR_LO(12'h7B0), .DBG_CSR_HI(12'h7B3)) dut (
        .clk(clk), .rst(rst),
        .core_req_i(core_req_i), .core_gnt_o(core_gnt_o), .core_addr_i(core_addr_i),
        .core_op_i(core_op_i), .core_wdata_i(core_wdata_i), .core_priv_i(core_priv_i),
        .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o), .core_err_o(core_err_o),
        .dbg_req_i(dbg_req_i), .dbg_gnt_o(dbg_gnt_o), .dbg_addr_i(dbg_addr_i),
        .dbg_op_i(dbg_op_i), .dbg_wdata_i(dbg_wdata_i),
        .dbg_rvalid_o(dbg_rvalid_o), .dbg_rdata_o(dbg_rdata_o), .dbg_err_o(dbg_err_o),
        .debug_mode_i(debug_mode_i),
        .csr_re_o(csr_re_o), .csr_we_o(csr_we_o), .csr_addr_o(csr_addr_o),
        .csr_wdata_o(csr_wdata_o), .csr_rdata_i(csr_rdata_i), .csr_illegal_i(csr_illegal_i)
    );

    typedef struct {
        logic        dbg;
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [1:0]  priv;
        logic        dm;
        logic [31:0] old;
        logic        ill;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic        exp_re;
        logic        exp_we;
        logic [31:0] exp_wd;
        int unsigned lat;
    } vec_t;

    typedef struct {
        logic        dbg;
        logic        err;
        logic [31:0] rdata;
        int unsigned cyc;
    } exp_t;

    exp_t        sbq[$];
    int unsigned n_chk = 0;
    int unsigned n_fail = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] all_or();
        return core_rdata_o | dbg_rdata_o | csr_wdata_o | {20'b0, csr_addr_o} |
               {24'b0, core_gnt_o, dbg_gnt_o, core_rvalid_o, dbg_rvalid_o,
                core_err_o, dbg_err_o, csr_re_o, csr_we_o};
    endfunction

    // Response monitor: pops the scoreboard on every rvalid
    always @(negedge clk) begin
        if (core_rvalid_o || dbg_rvalid_o) begin
            check("both_rvalid", 32'(core_rvalid_o & dbg_rvalid_o), 32'd0);
            if (sbq.size() == 0) begin
                check("unexpected_rvalid", 32'(core_rvalid_o | dbg_rvalid_o), 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("resp_owner", 32'(dbg_rvalid_o), 32'(e.dbg));
                check("resp_err", 32'(dbg_rvalid_o ? dbg_err_o : core_err_o), 32'(e.err));
                check("resp_rdata", dbg_rvalid_o ? dbg_rdata_o : core_rdata_o, e.rdata);
                check("resp_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_gnt(output logic got, output int unsigned waits);
        got = 1'b0;
        waits = 0;
        for (int w = 0; w < 20; w++) begin
            #1;
            if (core_gnt_o || dbg_gnt_o) begin
                got = 1'b1;
                break;
            end
            waits++;
            @(negedge clk);
        end
    endtask

    task automatic drop_and_scramble();
        core_req_i   = 1'b0;
        dbg_req_i    = 1'b0;
        core_addr_i  = 12'hFFF;
        dbg_addr_i   = 12'hFFF;
        core_op_i    = ~core_op_i;
        dbg_op_i     = ~dbg_op_i;
        core_wdata_i = ~core_wdata_i;
        dbg_wdata_i  = ~dbg_wdata_i;
    endtask

    vec_t        v[15];
    logic        got;
    int unsigned waits, prev_lat;
    logic        bad_re, bad_we;
    logic        seq[4];
    logic        exp_seq[4];
    int unsigned grants;

    initial begin
        //        dbg   op     addr     wdata         priv  dm    old           ill   err   rdata         re    we    wd            lat
        v[0]  = '{1'b0, 2'd0, 12'hF14, 32'h0,        2'd3, 1'b0, 32'h11111111, 1'b0, 1'b0, 32'h11111111, 1'b1, 1'b0, 32'h0,    3};
        v[1]  = '{1'b0, 2'd2, 12'h300, 32'h8,        2'd3, 1'b0, 32'h1880,     1'b0, 1'b0, 32'h1880,     1'b1, 1'b1, 32'h1888, 4};
        v[2]  = '{1'b0, 2'd1, 12'h7B0, 32'h5,        2'd3, 1'b0, 32'h1234,     1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0,    1};
        v[3]  = '{1'b0, 2'd1, 12'h7B0, 32'h5,        2'd3, 1'b1, 32'h3,        1'b0, 1'b0, 32'h3,        1'b1, 1'b1, 32'h5,    4};
        v[4]  = '{1'b0, 2'd0, 12'h300, 32'h0,        2'd0, 1'b0, 32'h1234,     1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0,    1};
        v[5]  = '{1'b0, 2'd1, 12'hF14, 32'h1,        2'd3, 1'b0, 32'h11111111, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0,    3};
        v[6]  = '{1'b0, 2'd3, 12'hF14, 32'h0,        2'd3, 1'b0, 32'h11111111, 1'b0, 1'b0, 32'h11111111, 1'b1, 1'b0, 32'h0,    3};
        v[7]  = '{1'b0, 2'd3, 12'h300, 32'h880,      2'd3, 1'b0, 32'h1888,     1'b0, 1'b0, 32'h1888,     1'b1, 1'b1, 32'h1008, 4};
        v[8]  = '{1'b1, 2'd1, 12'h7B1, 32'hA5,       2'd0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'hA5,   4};
        v[9]  = '{1'b0, 2'd0, 12'h123, 32'h0,        2'd1, 1'b0, 32'h5555,     1'b1, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0,    3};
        v[10] = '{1'b0, 2'd0, 12'h300, 32'h0,        2'd1, 1'b0, 32'h1234,     1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0,    1};
        v[11] = '{1'b0, 2'd2, 12'h340, 32'h0,        2'd3, 1'b0, 32'h77,       1'b0, 1'b0, 32'h77,       1'b1, 1'b0, 32'h0,    3};
        v[12] = '{1'b1, 2'd0, 12'hF11, 32'h0,        2'd0, 1'b0, 32'hDEAD,     1'b0, 1'b0, 32'hDEAD,     1'b1, 1'b0, 32'h0,    3};
        v[13] = '{1'b0, 2'd1, 12'hC00, 32'h0,        2'd3, 1'b0, 32'h99,       1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0,    3};
        v[14] = '{1'b1, 2'd2, 12'h7B2, 32'hF0,       2'd3, 1'b0, 32'h0F,       1'b0, 1'b0, 32'h0F,       1'b1, 1'b1, 32'hFF,   4};

        rst = 1'b1;
        core_req_i = 1'b0; core_addr_i = '0; core_op_i = '0; core_wdata_i = '0; core_priv_i = 2'd3;
        dbg_req_i = 1'b0;  dbg_addr_i = '0;  dbg_op_i = '0;  dbg_wdata_i = '0;
        debug_mode_i = 1'b0; csr_rdata_i = '0; csr_illegal_i = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", all_or(), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        prev_lat = 0;
        for (int i = 0; i < 15; i++) begin
            if (v[i].dbg) begin
                dbg_req_i = 1'b1; dbg_addr_i = v[i].addr; dbg_op_i = v[i].op; dbg_wdata_i = v[i].wdata;
            end else begin
                core_req_i = 1'b1; core_addr_i = v[i].addr; core_op_i = v[i].op; core_wdata_i = v[i].wdata;
            end
            core_priv_i = v[i].priv; debug_mode_i = v[i].dm;
            csr_rdata_i = v[i].old;  csr_illegal_i = v[i].ill;
            wait_gnt(got, waits);
            check($sformatf("gnt_seen_%0d", i), 32'(got), 32'd1);
            if (!got) begin
                drop_and_scramble();
                continue;
            end
            check($sformatf("gnt_owner_%0d", i), 32'({dbg_gnt_o, core_gnt_o}), v[i].dbg ? 32'd2 : 32'd1);
            check($sformatf("gnt_wait_%0d", i), waits, (prev_lat == 4) ? 32'd1 : 32'd0);
            sbq.push_back('{v[i].dbg, v[i].exp_err, v[i].exp_rdata, cyc + v[i].lat});
            bad_re = 1'b0;
            bad_we = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                if (k == 1) drop_and_scramble();
                if (csr_re_o !== (v[i].exp_re && k == 1)) bad_re = 1'b1;
                if (csr_re_o && csr_addr_o !== v[i].addr) bad_re = 1'b1;
                if (csr_we_o !== (v[i].exp_we && k == 3)) bad_we = 1'b1;
                if (csr_we_o && (csr_wdata_o !== v[i].exp_wd || csr_addr_o !== v[i].addr)) bad_we = 1'b1;
            end
            check($sformatf("re_seq_%0d", i), 32'(bad_re), 32'd0);
            check($sformatf("we_seq_%0d", i), 32'(bad_we), 32'd0);
            prev_lat = v[i].lat;
        end

        // Reset during the EVAL cycle of a write: nothing written, nothing answered
        core_req_i = 1'b1; core_addr_i = 12'h340; core_op_i = 2'd1; core_wdata_i = 32'h1234;
        core_priv_i = 2'd3; debug_mode_i = 1'b0; csr_rdata_i = 32'h0; csr_illegal_i = 1'b0;
        wait_gnt(got, waits);
        check("rst_gnt_seen", 32'(got), 32'd1);
        @(negedge clk);
        drop_and_scramble();
        check("rst_read_strobe", 32'(csr_re_o), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_no_we", 32'(csr_we_o), 32'd0);
        check("rst_no_rvalid", 32'({core_rvalid_o, dbg_rvalid_o}), 32'd0);
        check("rst_outputs", all_or(), 32'd0);
        rst = 1'b0;
        core_req_i = 1'b1; core_addr_i = 12'hF14; core_op_i = 2'd0;
        #1;
        check("rst_idle_gnt", 32'(core_gnt_o), 32'd1);
        #1;
        core_req_i = 1'b0;
        bad_we = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (csr_we_o || csr_re_o) bad_we = 1'b1;
        end
        check("rst_quiet_after", 32'(bad_we), 32'd0);

        // Arbitration with both requesters held continuously
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        core_addr_i = 12'hF14; core_op_i = 2'd0; core_wdata_i = '0; core_priv_i = 2'd3;
        dbg_addr_i = 12'h7B0;  dbg_op_i = 2'd0;  dbg_wdata_i = '0;
        csr_rdata_i = 32'h42;  csr_illegal_i = 1'b0;
        core_req_i = 1'b1; dbg_req_i = 1'b1;
`ifdef CSR_ARB_RR_EN
        exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        grants = 0;
        for (int c = 0; c < 60 && grants < 4; c++) begin
            #1;
            if (core_gnt_o || dbg_gnt_o) begin
                seq[grants] = dbg_gnt_o;
                sbq.push_back('{dbg_gnt_o, 1'b0, 32'h42, cyc + 3});
                grants++;
            end
            @(negedge clk);
        end
        core_req_i = 1'b0; dbg_req_i = 1'b0;
        check("arb_grants", grants, 32'd4);
        for (int g = 0; g < 4; g++) begin
            if (g < int'(grants)) check($sformatf("arb_owner_%0d", g), 32'(seq[g]), 32'(exp_seq[g]));
        end

        repeat (8) @(negedge clk);
        check("sb_drain", sbq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
